// File: rtl/arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        DONE_IF,
        DONE_DM
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch was waiting; forces a fetch grant at the cap.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_if_req,
    input  logic i_dm_grant,
    input  logic i_if_grant,
    output logic o_force_if
);

    localparam logic [3:0] CntMax = 4'(STARVE_MAX);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (i_if_grant) begin
            r_cnt <= 4'd0;
        end else if (i_dm_grant && i_if_req && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_force_if = (r_cnt == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-ported memory with a req/ack handshake,
// returning read data with a one-cycle ready pulse and aborting accesses that never get acked.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX  = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_ready,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [3:0]  i_dm_be,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_ready,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

    arb_state_e  r_state, w_state_next;
    logic [7:0]  r_tmo;
    logic        r_err;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr, r_mem_wdata;
    logic [31:0] r_if_rdata, r_dm_rdata;

    logic w_grant, w_own, w_force_if, w_tmo_hit, w_busy, w_done;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .i_if_req   (i_if_req),
        .i_dm_grant (w_grant && (w_own == OWN_DM)),
        .i_if_grant (w_grant && (w_own == OWN_IF)),
        .o_force_if (w_force_if)
    );

    assign w_tmo_hit = (r_tmo == TmoLast);
    assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_DM);
    assign w_done    = (r_state == DONE_IF) || (r_state == DONE_DM);

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_own        = OWN_DM;
        case (r_state)
            IDLE: begin
                if (i_dm_req || i_if_req) begin
                    w_grant = 1'b1;
                    if (i_dm_req && !(i_if_req && w_force_if)) begin
                        w_own        = OWN_DM;
                        w_state_next = BUSY_DM;
                    end else begin
                        w_own        = OWN_IF;
                        w_state_next = BUSY_IF;
                    end
                end
            end
            BUSY_IF: if (i_mem_ack || w_tmo_hit) w_state_next = DONE_IF;
            BUSY_DM: if (i_mem_ack || w_tmo_hit) w_state_next = DONE_DM;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tmo       <= 8'd0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_if_rdata  <= 32'h0;
            r_dm_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_tmo <= 8'd0;
                r_err <= 1'b0;
                if (w_own == OWN_DM) begin
                    r_mem_we    <= i_dm_we;
                    r_mem_be    <= i_dm_be;
                    r_mem_addr  <= i_dm_addr;
                    r_mem_wdata <= i_dm_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= 4'hF;
                    r_mem_addr  <= i_if_addr;
                    r_mem_wdata <= 32'h0;
                end
            end
            if (w_busy) begin
                if (i_mem_ack) begin
                    // Stores leave the last load result intact.
                    if (r_state == BUSY_IF) r_if_rdata <= i_mem_rdata;
                    else if (!r_mem_we)     r_dm_rdata <= i_mem_rdata;
                end else if (w_tmo_hit) begin
                    r_err <= 1'b1;
                    if (r_state == BUSY_IF) r_if_rdata <= ERR_RDATA;
                    else                    r_dm_rdata <= ERR_RDATA;
                end else begin
                    r_tmo <= r_tmo + 8'd1;
                end
            end
        end
    end

    assign o_mem_req   = w_busy;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_if_ready  = (r_state == DONE_IF);
    assign o_dm_ready  = (r_state == DONE_DM);
    assign o_err       = w_done && r_err;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory port.
- Grants one requester at a time and registers the address and write data at grant.
- Drives a req/ack memory handshake and returns read data with a one-cycle ready pulse. The pipeline stalls on its own when it sees req high and ready low.
- Data accesses have priority. A starvation counter forces a fetch grant after STARVE_MAX consecutive data grants taken while a fetch was waiting.

Parameters:
- STARVE_MAX, 4: consecutive contested data grants before fetch is forced; range 1..15.
- TIMEOUT_CYC, 64: BUSY cycles without mem_ack before the access is aborted; range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word, valid when if_ready
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = write
- dm_be  in  4  byte enables
- dm_addr  in  32  data address
- dm_wdata  in  32  write data
- dm_rdata  out  32  load data, valid when dm_ready
- dm_ready  out  1  one-cycle completion pulse for data
- err  out  1  one-cycle pulse, coincident with ready, when the access timed out
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write strobe
- mem_be  out  4  memory byte enables
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: every output is 0, state is IDLE, starve_cnt = 0, timeout counter = 0. Applies on the next clk edge, including mid-transaction; mem_req drops the cycle after reset is sampled.
- States and transitions:
  - IDLE → BUSY_IF or BUSY_DM on grant; otherwise stays in IDLE.
  - BUSY_x → DONE_x on mem_ack or on timeout.
  - DONE_x → IDLE unconditionally.
- Grant (IDLE only):
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both, with starve_cnt == STARVE_MAX: grant IF.
  - Both, otherwise: grant DM.
- At grant, register addr, we, be and wdata into the mem_* output registers. For IF, mem_we = 0, mem_be = 4'hF and mem_wdata = 0.
- mem_req = 1 exactly while in BUSY_x. mem_* fields are stable throughout BUSY.
- starve_cnt:
  - DM grant while if_req = 1: increment, saturating at STARVE_MAX.
  - Any IF grant: clear to 0.
  - DM grant with if_req = 0: unchanged.
- BUSY, mem_ack = 1: capture mem_rdata into the owner's rdata register and go to DONE. A DM write does not update dm_rdata.
- BUSY timeout: the counter starts at 0 on BUSY entry and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYC − 1 without ack, go to DONE with err flagged and owner rdata = 0. mem_req drops on the DONE transition.
- DONE_x: assert the owner's ready (and err if flagged) for exactly one cycle. Requests are ignored in DONE.
- Requesters may keep req high after ready to issue the next access; it is sampled in the following IDLE cycle.
- Latency: a request sampled in IDLE at cycle t with zero-wait memory (ack in the first BUSY cycle) gets ready at t+2. Back-to-back throughput is one access per 3 cycles minimum.
- mem_ack while in IDLE or DONE (late or spurious) is ignored and has no effect.
- if_req and dm_req both rising in the same IDLE cycle is resolved by the grant rule above. No grant occurs in the reset cycle.
- if_rdata and dm_rdata hold their last value until their next completion.

Decomposition:
- Package arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM, DONE_IF, DONE_DM);
  - the owner encoding OWN_IF = 0, OWN_DM = 1;
  - the constant ERR_RDATA = 32'h0.
- One sub-module, arb_starve_ctr, contains the saturating starvation counter and its force_if output. Everything else lives in mem_port_arbiter.

Test Plan:
- Fetch only, zero-wait memory: if_req = 1, if_addr = 0x100, ack with mem_rdata = 0xE3A01005 in the first BUSY cycle → if_ready at t+2, if_rdata = 0xE3A01005, mem_we = 0.
- Contention: both requesting at t, dm_we = 1, dm_addr = 0x2000, dm_wdata = 0xCAFEF00D, dm_be = 0xF → DM granted first with mem_we = 1 and mem_addr = 0x2000; IF granted in the next IDLE; dm_rdata unchanged.
- Starvation, STARVE_MAX = 4: both held continuously → grant order DM, DM, DM, DM, IF, then DM; starve_cnt reads 4 then 0.
- Wait states: memory acks 5 cycles into BUSY → mem_req high for exactly 5 cycles with mem_addr stable; ready in the cycle after ack.
- Timeout, TIMEOUT_CYC = 8, no ack → mem_req high for 8 cycles, then dm_ready = 1 with err = 1 and dm_rdata = 0; a mem_ack 3 cycles later is ignored.
- Reset mid-BUSY_DM → the next cycle has mem_req = 0, state IDLE, no ready and no err pulse; a fetch issued after reset completes normally.
